// File: rtl/coin_conditioner.sv
// Synchronises and debounces the three coin sensors, queues accepted insertions
// and replays them to the vending FSM as single-cycle coin codes.
module coin_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          coin5_raw,
    input  logic                          coin10_raw,
    input  logic                          coin20_raw,
    input  logic                          hold,
    input  logic                          clr_ovf,
    output logic [1:0]                    coin_out,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          fifo_full,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    logic [2:0]    raw;
    logic [2:0]    s1, s2, stable, stable_d, arm, pend;
    logic [1:0]    sync_ok;
    logic [CW-1:0] cnt [3];
    logic [2:0]    rise, drop, grant;
    logic [1:0]    push_code;
    logic          push, pop, empty;
    logic [1:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    state_t        state;
    logic [GW-1:0] gap_cnt;

    // Bit 0 = 5, bit 1 = 10, bit 2 = 20; the coin code of bit i is i+1.
    assign raw   = {coin20_raw, coin10_raw, coin5_raw};
    assign rise  = stable & ~stable_d & arm;
    assign drop  = rise & pend;
    assign empty = (count == '0);
    assign pop   = (state == IDLE) && !empty && !hold;

    assign pending   = count;
    assign fifo_full = (count == (PW+1)'(FIFO_DEPTH));

    // sync_ok marks when s2 reflects the real line, so a line held high
    // through reset cannot look released and arm itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_d <= '0;
            arm      <= '0;
            sync_ok  <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            sync_ok  <= {sync_ok[0], 1'b1};
            stable_d <= stable;
            arm      <= arm | ({3{sync_ok[1]}} & ~stable & ~s2);
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant     = 3'b000;
        push_code = 2'b00;
        if (!fifo_full) begin
            if (pend[0]) begin
                grant     = 3'b001;
                push_code = 2'b01;
            end else if (pend[1]) begin
                grant     = 3'b010;
                push_code = 2'b10;
            end else if (pend[2]) begin
                grant     = 3'b100;
                push_code = 2'b11;
            end
        end
    end

    assign push = |grant;

    // An event landing on a still-set pend bit is lost; the drop beats clr_ovf.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            pend <= (pend & ~grant) | (rise & ~pend);
            if (|drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_code;
    end

    // The IDLE cycle that follows a coin is the last forced gap cycle, so
    // GAP itself only covers any additional ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            coin_out <= 2'b00;
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    coin_out <= 2'b00;
                    if (pop) begin
                        state    <= EMIT;
                        coin_out <= mem[rd_ptr];
                    end
                end
                EMIT: begin
                    coin_out <= 2'b00;
                    gap_cnt  <= '0;
                    state    <= (GAP_CYCLES > 1) ? GAP : IDLE;
                end
                GAP: begin
                    coin_out <= 2'b00;
                    if (gap_cnt >= GW'(GAP_CYCLES - 2))
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    coin_out <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_conditioner.sv
// Scoreboard bench for coin_conditioner: stimulus pushes expected coin codes,
// a negedge monitor pops and compares every non-zero coin_out.
module tb_coin_conditioner;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin5_raw, coin10_raw, coin20_raw;
    logic       hold, clr_ovf;
    logic [1:0] coin_out;
    logic [2:0] pending;
    logic       fifo_full, overflow;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         emitCount = 0;
    int         e0, start;
    logic [1:0] expQ [$];
    int         emitCycles [$];
    logic [1:0] prevOut = 2'b00;

    coin_conditioner dut (
        .clk        (clk),
        .rst        (rst),
        .coin5_raw  (coin5_raw),
        .coin10_raw (coin10_raw),
        .coin20_raw (coin20_raw),
        .hold       (hold),
        .clr_ovf    (clr_ovf),
        .coin_out   (coin_out),
        .pending    (pending),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every emitted coin must be the next expected one and last a single cycle.
    always @(negedge clk) begin
        if (coin_out != 2'b00) begin
            emitCount++;
            emitCycles.push_back(cyc);
            checks++;
            if (prevOut != 2'b00) begin
                errors++;
                $display("[TB] FAIL pulse_width coin_out=%b also non-zero last cycle (%b), required single-cycle pulse", coin_out, prevOut);
            end
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_coin coin_out=%b at cycle %0d, required 00 (nothing queued)", coin_out, cyc);
            end else begin
                logic [1:0] want;
                want = expQ.pop_front();
                if (coin_out !== want) begin
                    errors++;
                    $display("[TB] FAIL coin_order coin_out=%b at cycle %0d, required %b", coin_out, cyc, want);
                end
            end
        end
        prevOut = coin_out;
    end

    initial begin
        #400000;
        $display("[TB] FAIL timeout simulation did not finish, required completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setRaw(input int line, input logic v);
        case (line)
            0:       coin5_raw  = v;
            1:       coin10_raw = v;
            default: coin20_raw = v;
        endcase
    endtask

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Drives one pulse; a coin is expected only when the caller says so.
    task automatic applyStimulus(input int line, input int highCycles, input int lowCycles,
                                 input bit expectCoin);
        if (expectCoin) expQ.push_back(2'(line + 1));
        setRaw(line, 1'b1);
        tick(highCycles);
        setRaw(line, 1'b0);
        tick(lowCycles);
    endtask

    function automatic int lastEmit(input int back);
        if (emitCycles.size() > back)
            return emitCycles[emitCycles.size() - 1 - back];
        return -1;
    endfunction

    initial begin
        rst        = 1'b1;
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        coin20_raw = 1'b0;
        hold       = 1'b0;
        clr_ovf    = 1'b0;
        tick(3);
        checkOutput("reset_coin_out", coin_out, 0);
        checkOutput("reset_pending", pending, 0);
        checkOutput("reset_fifo_full", fifo_full, 0);
        checkOutput("reset_overflow", overflow, 0);
        rst = 1'b0;
        tick(6);

        $display("[TB] latency: single 10 coin");
        e0    = emitCount;
        start = cyc;
        applyStimulus(1, 10, 15, 1'b1);
        checkOutput("latency_count", emitCount - e0, 1);
        checkOutput("latency_edge", lastEmit(0) - start, DEB + 5);
        checkOutput("latency_pending", pending, 0);

        $display("[TB] debounce: 3-cycle glitch then 4-cycle pulse");
        e0 = emitCount;
        applyStimulus(0, DEB - 1, 14, 1'b0);
        checkOutput("glitch_count", emitCount - e0, 0);
        checkOutput("glitch_pending", pending, 0);
        applyStimulus(0, DEB, 14, 1'b1);
        checkOutput("min_pulse_count", emitCount - e0, 1);

        $display("[TB] three coins on one edge");
        e0    = emitCount;
        start = cyc;
        expQ.push_back(2'b01);
        expQ.push_back(2'b10);
        expQ.push_back(2'b11);
        coin5_raw  = 1'b1;
        coin10_raw = 1'b1;
        coin20_raw = 1'b1;
        tick(8);
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        coin20_raw = 1'b0;
        tick(20);
        checkOutput("simul_count", emitCount - e0, 3);
        checkOutput("simul_first_edge", lastEmit(2) - start, DEB + 5);
        checkOutput("simul_spacing_a", lastEmit(1) - lastEmit(2), 2);
        checkOutput("simul_spacing_b", lastEmit(0) - lastEmit(1), 2);
        checkOutput("simul_overflow", overflow, 0);

        $display("[TB] hold while three coins are inserted");
        hold = 1'b1;
        e0   = emitCount;
        applyStimulus(2, 6, 12, 1'b1);
        applyStimulus(0, 6, 12, 1'b1);
        applyStimulus(1, 6, 12, 1'b1);
        checkOutput("hold_no_emit", emitCount - e0, 0);
        checkOutput("hold_pending", pending, 3);
        hold = 1'b0;
        tick(12);
        checkOutput("hold_release_count", emitCount - e0, 3);
        checkOutput("hold_spacing_a", lastEmit(1) - lastEmit(2), 2);
        checkOutput("hold_spacing_b", lastEmit(0) - lastEmit(1), 2);
        checkOutput("hold_pending_after", pending, 0);

        $display("[TB] fill FIFO, hold one in pend, drop one");
        hold = 1'b1;
        e0   = emitCount;
        repeat (4) applyStimulus(2, 6, 12, 1'b1);
        checkOutput("full_flag", fifo_full, 1);
        checkOutput("full_pending", pending, 4);
        applyStimulus(2, 6, 12, 1'b1);
        checkOutput("backpressure_pending", pending, 4);
        checkOutput("backpressure_no_ovf", overflow, 0);
        applyStimulus(2, 6, 12, 1'b0);
        checkOutput("drop_sets_ovf", overflow, 1);
        hold = 1'b0;
        tick(20);
        checkOutput("full_release_count", emitCount - e0, 5);
        checkOutput("full_release_pending", pending, 0);
        checkOutput("full_release_flag", fifo_full, 0);
        checkOutput("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        checkOutput("ovf_cleared", overflow, 0);

        $display("[TB] line held high through reset");
        coin20_raw = 1'b1;
        rst        = 1'b1;
        tick(3);
        rst = 1'b0;
        expQ.delete();
        e0 = emitCount;
        tick(25);
        checkOutput("held_line_no_coin", emitCount - e0, 0);
        coin20_raw = 1'b0;
        tick(14);
        applyStimulus(2, 6, 14, 1'b1);
        checkOutput("rearm_coin", emitCount - e0, 1);

        $display("[TB] reset with coins queued");
        hold = 1'b1;
        applyStimulus(0, 6, 12, 1'b1);
        applyStimulus(1, 6, 12, 1'b1);
        checkOutput("pre_reset_pending", pending, 2);
        rst = 1'b1;
        tick(1);
        checkOutput("mid_reset_coin_out", coin_out, 0);
        checkOutput("mid_reset_pending", pending, 0);
        rst = 1'b0;
        expQ.delete();
        e0   = emitCount;
        hold = 1'b0;
        tick(30);
        checkOutput("post_reset_no_emit", emitCount - e0, 0);

        $display("[TB] randomized pulses");
        for (int n = 0; n < 30; n++) begin
            int line, len, low;
            line = $urandom_range(0, 2);
            len  = $urandom_range(1, 8);
            low  = $urandom_range(10, 16);
            applyStimulus(line, len, low, len >= DEB);
        end
        tick(20);
        checkOutput("random_queue_drained", expQ.size(), 0);
        checkOutput("random_pending", pending, 0);
        checkOutput("random_overflow", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
